// File: rtl/wb_master_ctrl_if.sv
// Wishbone classic bus bundle between the initiator (master) and a target (slave).
interface wb_master_ctrl_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic              wbm_cyc_o;
    logic              wbm_stb_o;
    logic              wbm_we_o;
    logic [AW-1:0]     wbm_adr_o;
    logic [DW-1:0]     wbm_dat_o;
    logic [DW/8-1:0]   wbm_sel_o;
    logic [DW-1:0]     wbm_dat_i;
    logic              wbm_ack_i;
    logic              wbm_err_i;

    modport master (
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o,
        input  wbm_dat_i, wbm_ack_i, wbm_err_i
    );

    modport slave (
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o,
        output wbm_dat_i, wbm_ack_i, wbm_err_i
    );
endinterface

// File: rtl/wb_master_ctrl.sv
// Single-beat Wishbone classic initiator: command port in, bus cycle out,
// result (data + ok/err/timeout code) returned on a response port.
module wb_master_ctrl #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 1023
) (
    input  logic              wbm_clk_i,
    input  logic              wbm_rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [AW-1:0]     cmd_addr,
    input  logic [DW-1:0]     cmd_wdata,
    input  logic [DW/8-1:0]   cmd_sel,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DW-1:0]     rsp_rdata,
    output logic [1:0]        rsp_code,
    output logic [15:0]       txn_cnt,
    output logic [7:0]        err_cnt,
    wb_master_ctrl_if.master  wb
);
    localparam int SW = DW / 8;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT);

    localparam logic [1:0] CODE_OK  = 2'b00;
    localparam logic [1:0] CODE_ERR = 2'b01;
    localparam logic [1:0] CODE_TMO = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            cyc_q, cyc_d;
    logic            we_q, we_d;
    logic [AW-1:0]   adr_q, adr_d;
    logic [DW-1:0]   dat_q, dat_d;
    logic [SW-1:0]   sel_q, sel_d;
    logic [CW-1:0]   tmo_q, tmo_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic [1:0]      code_q, code_d;
    logic [15:0]     txn_q, txn_d;
    logic [7:0]      err_q, err_d;

    // cyc/stb come straight from a flop so the async reset drops them at once.
    always_ff @(posedge wbm_clk_i or negedge wbm_rst_n) begin
        if (!wbm_rst_n) begin
            state_q <= ST_IDLE;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            tmo_q   <= '0;
            rdata_q <= '0;
            code_q  <= CODE_OK;
            txn_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            tmo_q   <= tmo_d;
            rdata_q <= rdata_d;
            code_q  <= code_d;
            txn_q   <= txn_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        we_d    = we_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        tmo_d   = tmo_q;
        rdata_d = rdata_q;
        code_d  = code_q;
        txn_d   = txn_q;
        err_d   = err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    we_d    = cmd_we;
                    adr_d   = cmd_addr;
                    dat_d   = cmd_wdata;
                    sel_d   = cmd_sel;
                    tmo_d   = '0;
                    cyc_d   = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (wb.wbm_err_i || wb.wbm_ack_i || (tmo_q == TMO_LAST)) begin
                    cyc_d   = 1'b0;
                    state_d = ST_RESP;
                    txn_d   = txn_q + 16'd1;
                    rdata_d = '0;
                    // err outranks ack, which outranks the timeout on the same edge
                    if (wb.wbm_err_i) begin
                        code_d = CODE_ERR;
                    end else if (wb.wbm_ack_i) begin
                        code_d = CODE_OK;
                        if (!we_q) begin
                            rdata_d = wb.wbm_dat_i;
                        end
                    end else begin
                        code_d = CODE_TMO;
                    end
                    if ((code_d != CODE_OK) && (err_q != 8'hFF)) begin
                        err_d = err_q + 8'd1;
                    end
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cyc_d   = 1'b0;
            end
        endcase
    end

    assign cmd_ready     = (state_q == ST_IDLE);
    assign rsp_valid     = (state_q == ST_RESP);
    assign rsp_rdata     = rdata_q;
    assign rsp_code      = code_q;
    assign txn_cnt       = txn_q;
    assign err_cnt       = err_q;

    assign wb.wbm_cyc_o  = cyc_q;
    assign wb.wbm_stb_o  = cyc_q;
    assign wb.wbm_we_o   = we_q;
    assign wb.wbm_adr_o  = adr_q;
    assign wb.wbm_dat_o  = dat_q;
    assign wb.wbm_sel_o  = sel_q;
endmodule

// File: tb/tb_wb_master_ctrl.sv
// Directed bench for wb_master_ctrl with a configurable register slave and a
// transaction-level reference model checked every cycle.
module tb_wb_master_ctrl;
    localparam int T = 7;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_sel;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_code;
    logic [15:0] txn_cnt;
    logic [7:0]  err_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    wb_master_ctrl_if #(.AW(32), .DW(32)) bus ();

    wb_master_ctrl #(.AW(32), .DW(32), .TIMEOUT(T)) dut (
        .wbm_clk_i (clk),
        .wbm_rst_n (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .cmd_sel   (cmd_sel),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_code  (rsp_code),
        .txn_cnt   (txn_cnt),
        .err_cnt   (err_cnt),
        .wb        (bus)
    );

    always #5 clk = ~clk;

    // Slave: ack/err asserted in a chosen strobe cycle (1-based), 0 = never.
    int          ack_at = 0;
    int          err_at = 0;
    logic        force_en = 1'b0;
    logic [31:0] force_val = '0;
    logic        stray = 1'b0;
    int          scnt;
    logic [31:0] slave_mem [0:7] = '{default: 32'h0};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) scnt <= 0;
        else if (bus.wbm_stb_o) scnt <= scnt + 1;
        else scnt <= 0;
    end

    assign bus.wbm_ack_i = stray | (bus.wbm_stb_o && (ack_at != 0) && (scnt == ack_at - 1));
    assign bus.wbm_err_i = stray | (bus.wbm_stb_o && (err_at != 0) && (scnt == err_at - 1));
    assign bus.wbm_dat_i = force_en ? force_val : slave_mem[bus.wbm_adr_o[4:2]];

    always @(posedge clk) begin
        if (bus.wbm_stb_o && bus.wbm_ack_i && !bus.wbm_err_i && bus.wbm_we_o)
            for (int b = 0; b < 4; b++)
                if (bus.wbm_sel_o[b]) slave_mem[bus.wbm_adr_o[4:2]][8*b +: 8] <= bus.wbm_dat_o[8*b +: 8];
    end

    // Reference model state
    logic [31:0] model_mem [0:7] = '{default: 32'h0};
    int          issued = 0;
    int          errs_now = 0;
    int          errs_prev = 0;
    logic        m_we = 1'b0;
    logic [31:0] m_adr = '0, m_dat = '0;
    logic [3:0]  m_sel = '0;
    logic [1:0]  e_code = '0;
    logic [31:0] e_rdata = '0;
    bit          chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            chk("cyc_eq_stb", {31'b0, bus.wbm_cyc_o}, {31'b0, bus.wbm_stb_o});
            chk("adr_o", bus.wbm_adr_o, m_adr);
            chk("dat_o", bus.wbm_dat_o, m_dat);
            chk("sel_o", {28'b0, bus.wbm_sel_o}, {28'b0, m_sel});
            chk("we_o", {31'b0, bus.wbm_we_o}, {31'b0, m_we});
            if (bus.wbm_stb_o) begin
                chk("req_cmd_ready", {31'b0, cmd_ready}, 32'd0);
                chk("req_rsp_valid", {31'b0, rsp_valid}, 32'd0);
                chk("req_txn_cnt", {16'b0, txn_cnt}, (issued - 1) & 32'hFFFF);
                chk("req_err_cnt", {24'b0, err_cnt}, errs_prev);
            end else begin
                chk("txn_cnt", {16'b0, txn_cnt}, issued & 32'hFFFF);
                chk("err_cnt", {24'b0, err_cnt}, errs_now);
                if (rsp_valid) begin
                    chk("rsp_code", {30'b0, rsp_code}, {30'b0, e_code});
                    chk("rsp_rdata", rsp_rdata, e_rdata);
                    chk("resp_cmd_ready", {31'b0, cmd_ready}, 32'd0);
                end else begin
                    chk("idle_cmd_ready", {31'b0, cmd_ready}, 32'd1);
                end
            end
        end
    end

    task automatic model_accept(input logic we, input logic [31:0] addr, wdata, input logic [3:0] sel,
                                input int a_at, e_at, input logic f_en, input logic [31:0] f_val,
                                output int len);
        logic [1:0] code;
        logic [31:0] rd;
        len  = T + 1;
        code = 2'b10;
        for (int c = 1; c <= T + 1; c++) begin
            if (e_at == c) begin code = 2'b01; len = c; break; end
            if (a_at == c) begin code = 2'b00; len = c; break; end
        end
        rd = '0;
        if (code == 2'b00) begin
            if (!we) rd = f_en ? f_val : model_mem[addr[4:2]];
            else for (int b = 0; b < 4; b++) if (sel[b]) model_mem[addr[4:2]][8*b +: 8] = wdata[8*b +: 8];
        end
        m_we = we; m_adr = addr; m_dat = wdata; m_sel = sel;
        e_code = code; e_rdata = rd;
        errs_prev = errs_now;
        if (code != 2'b00 && errs_now < 255) errs_now++;
        issued++;
    endtask

    task automatic do_cmd(input logic we, input logic [31:0] addr, wdata, input logic [3:0] sel,
                          input int a_at, e_at, input logic f_en, input logic [31:0] f_val, input int bp,
                          output logic [1:0] o_code, output logic [31:0] o_rdata, output int o_len, output int o_lat);
        int  len;
        bit  got;
        @(negedge clk);
        ack_at = a_at; err_at = e_at; force_en = f_en; force_val = f_val;
        rsp_ready = (bp == 0);
        cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_wdata = wdata; cmd_sel = sel;
        got = 0;
        for (int k = 0; k < 50; k++) begin
            if (cmd_ready) begin got = 1; break; end
            @(negedge clk);
        end
        chk("accept_wait", {31'b0, got}, 32'd1);
        @(posedge clk);
        model_accept(we, addr, wdata, sel, a_at, e_at, f_en, f_val, len);
        #1;
        if (bp == 0) cmd_valid = 1'b0;
        o_len = 0; o_lat = 0; got = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus.wbm_stb_o) o_len++;
            if (rsp_valid) begin o_lat = k; got = 1; break; end
        end
        chk("rsp_wait", {31'b0, got}, 32'd1);
        chk("stb_len", o_len, len);
        chk("rsp_latency", o_lat, len + 1);
        o_code = rsp_code; o_rdata = rsp_rdata;
        if (bp > 0) begin
            repeat (bp) begin
                @(negedge clk);
                chk("bp_rsp_valid", {31'b0, rsp_valid}, 32'd1);
            end
            cmd_valid = 1'b0;
            rsp_ready = 1'b1;
        end
        @(negedge clk);
        chk("rsp_consumed", {31'b0, rsp_valid}, 32'd0);
        chk("cmd_ready_back", {31'b0, cmd_ready}, 32'd1);
        $display("txn we=%0d adr=0x%0h code=%0d rdata=0x%0h stb_cycles=%0d latency=%0d txn_cnt=%0d err_cnt=%0d",
                 we, addr, o_code, o_rdata, o_len, o_lat, txn_cnt, err_cnt);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  oc;
        logic [31:0] ord;
        int          ol, olat;
        int          dummy_len;

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_sel = '0;
        rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        chk("rst_stb", {31'b0, bus.wbm_stb_o}, 32'd0);
        chk("rst_cyc", {31'b0, bus.wbm_cyc_o}, 32'd0);
        chk("rst_adr", bus.wbm_adr_o, 32'd0);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_txn", {16'b0, txn_cnt}, 32'd0);
        rst_n = 1'b1;
        chk_en = 1'b1;

        // Registered-ack slave: write then read back
        do_cmd(1'b1, 32'h0, 32'hA5A5_1234, 4'hF, 3, 0, 1'b0, '0, 0, oc, ord, ol, olat);
        chk("wr_code", {30'b0, oc}, 32'd0);
        chk("wr_rdata", ord, 32'd0);
        chk("wr_latency", olat, 32'd4);
        chk("wr_txn", {16'b0, txn_cnt}, 32'd1);
        do_cmd(1'b0, 32'h0, 32'h0, 4'hF, 3, 0, 1'b0, '0, 0, oc, ord, ol, olat);
        chk("rd_rdata", ord, 32'hA5A5_1234);
        chk("rd_txn", {16'b0, txn_cnt}, 32'd2);
        do_cmd(1'b0, 32'h1C, 32'h0, 4'hF, 3, 0, 1'b0, '0, 0, oc, ord, ol, olat);
        chk("rd1c_rdata", ord, 32'd0);

        // Zero-wait slave and partial byte write
        do_cmd(1'b0, 32'h0, 32'h0, 4'hF, 1, 0, 1'b0, '0, 0, oc, ord, ol, olat);
        chk("zw_latency", olat, 32'd2);
        do_cmd(1'b1, 32'h4, 32'h1122_3344, 4'h5, 1, 0, 1'b0, '0, 0, oc, ord, ol, olat);

        // Slave error in 2nd strobe cycle
        do_cmd(1'b0, 32'h0, 32'h0, 4'hF, 0, 2, 1'b0, '0, 0, oc, ord, ol, olat);
        chk("err_code", {30'b0, oc}, 32'd1);
        chk("err_rdata", ord, 32'd0);
        chk("err_stb_len", ol, 32'd2);
        chk("err_cnt1", {24'b0, err_cnt}, 32'd1);

        // ack and err together
        do_cmd(1'b0, 32'h0, 32'h0, 4'hF, 1, 1, 1'b1, 32'hFFFF_FFFF, 0, oc, ord, ol, olat);
        chk("both_code", {30'b0, oc}, 32'd1);
        chk("both_rdata", ord, 32'd0);

        // Silent slave, then ack in the final allowed cycle
        do_cmd(1'b0, 32'h4, 32'h0, 4'hF, 0, 0, 1'b0, '0, 0, oc, ord, ol, olat);
        chk("tmo_stb_len", ol, 32'd8);
        chk("tmo_code", {30'b0, oc}, 32'd2);
        chk("tmo_err_cnt", {24'b0, err_cnt}, 32'd3);
        do_cmd(1'b0, 32'h0, 32'h0, 4'hF, 8, 0, 1'b0, '0, 0, oc, ord, ol, olat);
        chk("late_ack_code", {30'b0, oc}, 32'd0);
        chk("late_ack_rdata", ord, 32'hA5A5_1234);

        // Backpressure with cmd_valid held high
        do_cmd(1'b0, 32'h4, 32'h0, 4'hF, 1, 0, 1'b0, '0, 5, oc, ord, ol, olat);
        chk("bp_rdata", ord, 32'h0022_0044);
        chk("bp_txn", {16'b0, txn_cnt}, 32'd10);

        // ack/err outside a cycle are ignored
        @(negedge clk);
        stray = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("stray_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        end
        stray = 1'b0;

        // Reset in the 2nd REQ cycle
        @(negedge clk);
        ack_at = 0; err_at = 0; force_en = 1'b0;
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 32'h8; cmd_wdata = 32'h0; cmd_sel = 4'hF;
        @(posedge clk);
        model_accept(1'b0, 32'h8, 32'h0, 4'hF, 0, 0, 1'b0, '0, dummy_len);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        chk("rst_mid_req", {31'b0, bus.wbm_stb_o}, 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_stb", {31'b0, bus.wbm_stb_o}, 32'd0);
        chk("rst_mid_cyc", {31'b0, bus.wbm_cyc_o}, 32'd0);
        chk("rst_mid_adr", bus.wbm_adr_o, 32'd0);
        chk("rst_mid_rdata", rsp_rdata, 32'd0);
        chk("rst_mid_code", {30'b0, rsp_code}, 32'd0);
        chk("rst_mid_txn", {16'b0, txn_cnt}, 32'd0);
        chk("rst_mid_err", {24'b0, err_cnt}, 32'd0);
        chk("rst_mid_ready", {31'b0, cmd_ready}, 32'd1);
        issued = 0; errs_now = 0; errs_prev = 0;
        m_we = 1'b0; m_adr = '0; m_dat = '0; m_sel = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        do_cmd(1'b0, 32'h0, 32'h0, 4'hF, 1, 0, 1'b0, '0, 0, oc, ord, ol, olat);
        chk("post_rst_rdata", ord, 32'hA5A5_1234);
        chk("post_rst_txn", {16'b0, txn_cnt}, 32'd1);

        // err_cnt saturation
        for (int i = 0; i < 256; i++)
            do_cmd(1'b0, 32'h0, 32'h0, 4'hF, 0, 1, 1'b0, '0, 0, oc, ord, ol, olat);
        chk("err_sat", {24'b0, err_cnt}, 32'hFF);
        chk("sat_txn", {16'b0, txn_cnt}, 32'd257);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/wb_master_ctrl.md
# wb_master_ctrl

Wishbone initiator that turns single-beat commands from a local valid/ready request port into classic Wishbone read/write cycles. It captures read data and completion status, and reports each result on a valid/ready response port. It is the master-side counterpart of the team's register-bank Wishbone slaves and drives them in block-level and chip-level benches and in firmware-less bring-up paths. It adds a bus timeout so that an unresponsive slave cannot hang the initiator.

## Interface
- AW, 32, address width.
- DW, 32, data width; sel width is DW/8.
- TIMEOUT, 1023, maximum number of cycles the strobe may stay high with no ack/err; counter width is $clog2(TIMEOUT+1).
- wbm_clk_i  in  1  clock.
- wbm_rst_n  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when high together with cmd_valid.
- cmd_we  in  1  1 = write, 0 = read.
- cmd_addr  in  AW  byte address.
- cmd_wdata  in  DW  write data.
- cmd_sel  in  DW/8  byte enables.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  DW  read data; 0 for writes and on error.
- rsp_code  out  2  00 = ok, 01 = slave err, 10 = timeout.
- wbm_cyc_o, wbm_stb_o  out  1  Wishbone cycle and strobe.
- wbm_adr_o  out  AW  Wishbone address.
- wbm_we_o  out  1  Wishbone write enable.
- wbm_dat_o  out  DW  Wishbone write data.
- wbm_sel_o  out  DW/8  Wishbone byte select.
- wbm_dat_i  in  DW  Wishbone read data.
- wbm_ack_i  in  1  Wishbone acknowledge.
- wbm_err_i  in  1  Wishbone error.
- txn_cnt  out  16  completed transactions, wraps at 0xFFFF→0.
- err_cnt  out  8  transactions with rsp_code≠00, saturates at 0xFF.

## Operation
- FSM states and behaviour:
  - IDLE: cmd_ready=1. On cmd_valid&cmd_ready, register we/addr/wdata/sel onto the wbm_* outputs, clear the timeout counter, and go to REQ.
  - REQ: cyc_o=stb_o=1. Address, data, sel and we are stable for the whole cycle. Each edge with neither ack_i nor err_i increments the counter.
    - err_i=1 → rsp_code=01, rdata=0, go to RESP.
    - else ack_i=1 → rsp_code=00; rdata=dat_i if read, else 0; go to RESP.
    - else counter==TIMEOUT → rsp_code=10, rdata=0, go to RESP.
  - RESP: rsp_valid=1. rsp_rdata and rsp_code are held stable. On rsp_ready, go to IDLE.
- Termination priority at one edge: err_i > ack_i > timeout. err_i and ack_i together report 01.
- ack_i and err_i are ignored outside REQ.
- cyc_o and stb_o always deassert together, at the same edge that leaves REQ. There are no back-to-back strobes, so slaves that gate on ack see a clean request drop.
- txn_cnt increments on every REQ→RESP transition. err_cnt increments on that transition when the code is not 00.
- New commands are never accepted while in REQ or RESP; cmd_ready=0 in those states.
- The wbm_adr/dat/sel/we outputs hold their last values after the cycle ends; they are changed only when a command is accepted.

## Timing
- Reset (async assert, sync release): state IDLE, cmd_ready=1, cyc_o=stb_o=we_o=0, adr_o=dat_o=sel_o=0, rsp_valid=0, rsp_rdata=0, rsp_code=00, txn_cnt=0, err_cnt=0, counter=0.
- Reset mid-transaction: cyc_o and stb_o drop immediately (asynchronously) and any pending response is discarded.
- Command accepted at edge E: stb_o is high from cycle E+1.
- Ack sampled at edge A: stb_o is low and rsp_valid is high from cycle A+1.
- With the team's registered-ack slave (ack two cycles after strobe), accept at E gives rsp_valid at E+4.
- Zero-wait slave (ack in the first strobe cycle): rsp_valid at E+2.
- Timeout: with no ack/err, stb_o stays high for exactly TIMEOUT+1 cycles. An ack arriving in the final cycle wins over the timeout.
- rsp_ready may be high before rsp_valid. The RESP→IDLE handshake takes one edge, so cmd_ready rises in the cycle after the handshake.
- Minimum command-to-command spacing is 3 cycles: accept, REQ with zero-wait ack, RESP with rsp_ready=1.

## Test plan
- Write then read back, using the team's register slave:
  - Write addr 0x0, data 0xA5A5_1234, sel 0xF → rsp_code 00, rsp_rdata 0, txn_cnt 1.
  - Read addr 0x0 → rsp_rdata 0xA5A5_1234, code 00, txn_cnt 2.
  - Read addr 0x1C → rsp_rdata 0.
- Slave err, with err_i pulsed in the 2nd strobe cycle of a read → code 01, rsp_rdata 0, err_cnt 1, stb_o low in the next cycle.
- Simultaneous ack_i=err_i=1 with dat_i=0xFFFF_FFFF → code 01, rsp_rdata 0.
- Timeout at TIMEOUT=7 with a silent slave → stb_o high for exactly 8 cycles, code 10, err_cnt increments.
  - Repeat with ack in the 8th cycle → code 00.
- Response backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid → rsp_valid and rsp_rdata stay stable, cmd_ready=0, cmd_valid is ignored; release → exactly one response is consumed.
- Reset asserted in the 2nd REQ cycle → cyc_o and stb_o drop in the same cycle, all outputs take reset values, and the next command completes normally.
